sti_deser: RTL

STI_DESER -- requirements
Module: sti_deser

---
 rtl/sti_deser.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sti_deser.sv
// rtl/sti_deser.sv - serial-to-parallel frame deserializer with FWFT output FIFO
//
// Collects frames of 8/16/24/32 serial bits into words and queues good frames.
// A frame is a maximal run of si_valid=1 cycles. Wrong-length frames are dropped
// with a frame_err pulse. Good frames that find the FIFO full are dropped with an
// overflow pulse.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   si_data, si_valid     serial bit and frame qualifier
//   cfg_length, cfg_msb   frame size code (8*(n+1) bits) and bit order, latched per frame
//   rd_ready              consumer pops head entry when rd_valid=1
//   rd_valid, rd_data,
//   rd_len                head entry (first-word-fall-through), right-aligned word and its length code
//   fifo_count            current occupancy
//   frame_err, overflow   one-cycle drop indications

module sti_deser #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     si_data,
  input  logic                     si_valid,
  input  logic [1:0]               cfg_length,
  input  logic                     cfg_msb,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [1:0]               rd_len,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  logic [1:0]      len_q, len_d;
  logic            msb_q, msb_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [31:0]     sr_q, sr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic [31:0]     mem_data_q [DEPTH];
  logic [31:0]     mem_data_d [DEPTH];
  logic [1:0]      mem_len_q [DEPTH];
  logic [1:0]      mem_len_d [DEPTH];

  logic [5:0]      n_bits;
  logic            good;
  logic            full;
  logic            push;
  logic            pop;

  assign n_bits = {1'b0, len_q, 3'b000} + 6'd8;
  assign full   = (count_q == FULL_CNT);
  assign pop    = rd_valid & rd_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    msb_d       = msb_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    good        = 1'b0;

    case (state_q)
      IDLE: begin
        if (si_valid) begin
          // First bit lands at bit 0 in both orders; config is frozen here.
          state_d = RECV;
          len_d   = cfg_length;
          msb_d   = cfg_msb;
          cnt_d   = 6'd1;
          sr_d    = {31'b0, si_data};
        end
      end
      RECV: begin
        if (si_valid) begin
          if (cnt_q != 6'd63) begin
            cnt_d = cnt_q + 6'd1;
          end
          if (msb_q) begin
            sr_d = {sr_q[30:0], si_data};
          end else if (cnt_q < 6'd32) begin
            sr_d[cnt_q[4:0]] = si_data;
          end
        end else begin
          state_d = IDLE;
          if (cnt_q == n_bits) begin
            good = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_len_d  = mem_len_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // A same-edge pop frees the slot, so a full FIFO still accepts the push.
    push       = good & (~full | pop);
    overflow_d = good & full & ~pop;

    if (push) begin
      mem_data_d[wr_ptr_q] = sr_q;
      mem_len_d[wr_ptr_q]  = len_q;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= 2'd0;
      msb_q       <= 1'b0;
      cnt_q       <= 6'd0;
      sr_q        <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= 32'd0;
        mem_len_q[i]  <= 2'd0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      msb_q       <= msb_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= mem_data_d[i];
        mem_len_q[i]  <= mem_len_d[i];
      end
    end
  end

  assign rd_valid   = (count_q != '0);
  // Gate with rd_valid so a drained FIFO shows zeros rather than stale entries.
  assign rd_data    = rd_valid ? mem_data_q[rd_ptr_q] : 32'd0;
  assign rd_len     = rd_valid ? mem_len_q[rd_ptr_q] : 2'd0;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule
